// File: rtl/gridworld_episode_monitor.sv
// Episode runner and specification monitor for the 8x8 gridworld.
// Applies the step2d movement rule to one action per handshake, evaluates the
// region predicates on every new cell and produces a registered verdict for:
// reach yellow, never touch red, discharge each blue visit on brown within
// DEADLINE steps, all within HORIZON steps.
module gridworld_episode_monitor #(
  parameter int unsigned HORIZON  = 16,
  parameter int unsigned DEADLINE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] x0,
  input  logic [2:0] y0,
  input  logic       act_valid,
  input  logic [2:0] act,
  output logic       act_ready,
  output logic [2:0] x,
  output logic [2:0] y,
  output logic [7:0] steps,
  output logic       done,
  output logic       accept,
  output logic       reject,
  output logic       timeout
);

  localparam int unsigned CW = 3;
  localparam int unsigned SW = 8;
  localparam int unsigned DW = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    PEND = 3'd2,
    ACC  = 3'd3,
    REJ  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] x_d, y_d;
  logic [SW-1:0] steps_d;
  logic [DW-1:0] dl_q, dl_d;
  logic          timeout_d;

  // Region predicates on a single cell
  function automatic logic is_blue(input logic [CW-1:0] cx, input logic [CW-1:0] cy);
    return (cx == CW'(3) || cx == CW'(4)) && (cy >= CW'(2) && cy <= CW'(5));
  endfunction

  function automatic logic is_edge(input logic [CW-1:0] c);
    return (c == CW'(0)) || (c == CW'(7));
  endfunction

  function automatic logic is_yellow(input logic [CW-1:0] cx, input logic [CW-1:0] cy);
    return is_edge(cx) && is_edge(cy);
  endfunction

  function automatic logic is_brown(input logic [CW-1:0] cy);
    return is_edge(cy);
  endfunction

  function automatic logic is_red(input logic [CW-1:0] cx, input logic [CW-1:0] cy);
    logic inner_col, edge_col;
    inner_col = (cx == CW'(1)) || (cx == CW'(6));
    edge_col  = is_edge(cx);
    return (inner_col && (cy == CW'(0) || cy == CW'(1) || cy == CW'(4) || cy == CW'(5)))
        || (edge_col  && (cy == CW'(1) || cy == CW'(4) || cy == CW'(5)));
  endfunction

  // A step is only possible while an episode is live and no start overrides it
  assign act_ready = ((state_q == RUN) || (state_q == PEND)) && !start;

  // Next-state: start/step selection, cell evaluation and horizon check
  always_comb begin
    logic [CW-1:0] dx, dy, cx, cy;
    state_t        base;
    logic [DW-1:0] base_dl;
    logic          do_eval;
    logic          stepped;

    state_d   = state_q;
    x_d       = x;
    y_d       = y;
    steps_d   = steps;
    dl_d      = dl_q;
    timeout_d = timeout;
    dx        = '0;
    dy        = '0;
    cx        = x;
    cy        = y;
    base      = state_q;
    base_dl   = dl_q;
    do_eval   = 1'b0;
    stepped   = 1'b0;

    unique case (act)
      3'd1, 3'd2, 3'd3: dx = CW'(1);
      3'd5, 3'd6, 3'd7: dx = CW'(7);
      default:          dx = CW'(0);
    endcase
    unique case (act)
      3'd0, 3'd1, 3'd7: dy = CW'(1);
      3'd3, 3'd4, 3'd5: dy = CW'(7);
      default:          dy = CW'(0);
    endcase

    if (start) begin
      cx        = x0;
      cy        = y0;
      base      = RUN;
      base_dl   = '0;
      steps_d   = '0;
      timeout_d = 1'b0;
      do_eval   = 1'b1;
    end else if (act_valid && act_ready) begin
      cx      = x + dx;
      cy      = y + dy;
      steps_d = (steps == '1) ? steps : steps + SW'(1);
      do_eval = 1'b1;
      stepped = 1'b1;
    end

    if (do_eval) begin
      x_d     = cx;
      y_d     = cy;
      state_d = base;
      dl_d    = base_dl;
      if (is_red(cx, cy)) begin
        state_d = REJ;
      end else if (is_brown(cy)) begin
        dl_d    = '0;
        state_d = is_yellow(cx, cy) ? ACC : RUN;
      end else if (is_blue(cx, cy)) begin
        state_d = PEND;
        dl_d    = DW'(DEADLINE);
      end else if (base == PEND) begin
        if (base_dl == DW'(1)) state_d = REJ;
        else                   dl_d    = base_dl - DW'(1);
      end
      // Horizon expiry only applies when no other verdict landed on this step
      if (stepped && steps_d == SW'(HORIZON) && (state_d == RUN || state_d == PEND)) begin
        state_d   = REJ;
        timeout_d = 1'b1;
      end
    end
  end

  // State, position and verdict registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x       <= '0;
      y       <= '0;
      steps   <= '0;
      dl_q    <= '0;
      done    <= 1'b0;
      accept  <= 1'b0;
      reject  <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      x       <= x_d;
      y       <= y_d;
      steps   <= steps_d;
      dl_q    <= dl_d;
      done    <= (state_d == ACC) || (state_d == REJ);
      accept  <= (state_d == ACC);
      reject  <= (state_d == REJ);
      timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_gridworld_episode_monitor.sv
// Bench for gridworld_episode_monitor: directed scenarios followed by random
// traffic, all compared against an episode-level reference model.
module tb_gridworld_episode_monitor;

  localparam int unsigned HORIZON  = 16;
  localparam int unsigned DEADLINE = 4;

  logic       clk = 1'b0;
  logic       rst, start, act_valid, act_ready;
  logic [2:0] x0, y0, act, x, y;
  logic [7:0] steps;
  logic       done, accept, reject, timeout;

  int tests = 0;
  int fails = 0;

  // Reference model: episode status in plain integers
  int m_x, m_y, m_steps;
  bit m_live;         // episode running, actions accepted
  int m_verdict;      // 0 none, 1 accepted, 2 rejected
  bit m_to;
  bit m_owe_brown;    // a blue visit not yet discharged
  int m_age;          // non-blue cells visited since the last blue cell

  gridworld_episode_monitor #(.HORIZON(HORIZON), .DEADLINE(DEADLINE)) dut (
    .clk(clk), .rst(rst), .start(start), .x0(x0), .y0(y0),
    .act_valid(act_valid), .act(act), .act_ready(act_ready),
    .x(x), .y(y), .steps(steps), .done(done), .accept(accept),
    .reject(reject), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic bit in_set(input int v, input int a, input int b, input int c, input int d);
    return (v == a) || (v == b) || (v == c) || (v == d);
  endfunction

  function automatic bit cell_red(input int cx, input int cy);
    return ((cx == 1 || cx == 6) && in_set(cy, 0, 1, 4, 5))
        || ((cx == 0 || cx == 7) && in_set(cy, 1, 4, 5, 5));
  endfunction

  function automatic bit cell_blue(input int cx, input int cy);
    return cx >= 3 && cx <= 4 && cy >= 2 && cy <= 5;
  endfunction

  task automatic finish_episode(input int verdict);
    m_verdict = verdict;
    m_live    = 1'b0;
  endtask

  task automatic model_visit(input int cx, input int cy);
    m_x = cx;
    m_y = cy;
    if (cell_red(cx, cy)) begin
      finish_episode(2);
    end else if (cy == 0 || cy == 7) begin
      m_owe_brown = 1'b0;
      if (cx == 0 || cx == 7) finish_episode(1);
    end else if (cell_blue(cx, cy)) begin
      m_owe_brown = 1'b1;
      m_age       = 0;
    end else if (m_owe_brown) begin
      m_age++;
      if (m_age >= DEADLINE) finish_episode(2);
    end
  endtask

  task automatic model_clock(input bit r, input bit s, input int sx, input int sy,
                             input bit v, input int a);
    int ddx, ddy;
    if (r) begin
      m_x = 0; m_y = 0; m_steps = 0; m_live = 0; m_verdict = 0; m_to = 0;
      m_owe_brown = 0; m_age = 0;
    end else if (s) begin
      m_steps = 0; m_verdict = 0; m_to = 0; m_owe_brown = 0; m_age = 0; m_live = 1;
      model_visit(sx, sy);
    end else if (v && m_live) begin
      ddx = (a >= 1 && a <= 3) ? 1 : (a >= 5) ? -1 : 0;
      ddy = (a <= 1 || a == 7) ? 1 : (a >= 3 && a <= 5) ? -1 : 0;
      m_steps = (m_steps < 255) ? m_steps + 1 : 255;
      model_visit((m_x + ddx + 8) % 8, (m_y + ddy + 8) % 8);
      if (m_live && m_steps == HORIZON) begin
        m_to = 1'b1;
        finish_episode(2);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check act_ready, clock, check registered outputs
  task automatic cyc(input bit r, input bit s, input int sx, input int sy,
                     input bit v, input int a);
    rst = r; start = s; x0 = 3'(sx); y0 = 3'(sy); act_valid = v; act = 3'(a);
    #1;
    if (!r) chk("act_ready", 32'(act_ready), 32'(m_live && !s));
    @(posedge clk);
    model_clock(r, s, sx, sy, v, a);
    @(negedge clk);
    chk("x", 32'(x), 32'(m_x));
    chk("y", 32'(y), 32'(m_y));
    chk("steps", 32'(steps), 32'(m_steps));
    chk("done", 32'(done), 32'(m_verdict != 0));
    chk("accept", 32'(accept), 32'(m_verdict == 1));
    chk("reject", 32'(reject), 32'(m_verdict == 2));
    chk("timeout", 32'(timeout), 32'(m_to));
  endtask

  task automatic act_n(input int a, input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1, a);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; x0 = '0; y0 = '0; act_valid = 1'b0; act = '0;
    model_clock(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 3);                 // idle: action not accepted

    // Accept path
    cyc(0, 1, 2, 2, 0, 0);
    act_n(1, 1);
    act_n(0, 4);
    act_n(6, 3);
    chk("accept_path_accept", 32'(accept), 32'd1);
    chk("accept_path_steps", 32'(steps), 32'd8);

    // Red cell
    cyc(0, 1, 2, 2, 0, 0);
    act_n(5, 1);
    chk("red_reject", 32'(reject), 32'd1);
    chk("red_timeout", 32'(timeout), 32'd0);
    act_n(2, 3);                           // held act_valid after done
    chk("red_hold_steps", 32'(steps), 32'd1);

    // Deadline miss
    cyc(0, 1, 4, 3, 0, 0);
    act_n(2, 4);
    chk("deadline_reject", 32'(reject), 32'd1);
    chk("deadline_steps", 32'(steps), 32'd4);

    // Horizon expiry with row wrap
    cyc(0, 1, 2, 2, 0, 0);
    act_n(4, 16);
    chk("horizon_timeout", 32'(timeout), 32'd1);
    chk("horizon_pos", 32'({x, y}), 32'({3'd2, 3'd2}));

    // Start beats a simultaneous action
    cyc(0, 1, 5, 2, 1, 1);
    chk("start_pos", 32'({x, y}), 32'({3'd5, 3'd2}));

    // Reset mid-episode, then red start cell
    act_n(0, 2);
    cyc(1, 1, 3, 3, 1, 1);
    chk("rst_done", 32'(done), 32'd0);
    cyc(0, 1, 6, 0, 0, 0);
    chk("red_start", 32'(reject), 32'd1);
    cyc(0, 1, 7, 7, 0, 0);
    chk("yellow_start", 32'(accept), 32'd1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 14) == 0),
          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
          ($urandom_range(0, 3) != 0),
          int'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gridworld_episode_monitor.md
# gridworld_episode_monitor

Sequential episode runner and specification monitor for the 8x8 gridworld. It consumes one 3-bit action per handshake and holds the agent position in registers. It applies the `step2d` movement rule and evaluates the region predicates (blue, yellow, brown, red) on every new cell. Its output is a registered accept/reject verdict for the task "reach yellow, never touch red, discharge every blue visit by reaching brown within DEADLINE steps, all within HORIZON steps". It sits directly downstream of `step2d` and the region detectors.

## Interface
- HORIZON, 16: maximum accepted steps per episode (1..255).
- DEADLINE, 4: steps allowed after leaving blue before brown must be reached (1..7).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; loads x0/y0 and begins an episode (any state).
- x0  in  3  start column.
- y0  in  3  start row.
- act_valid  in  1  action offered.
- act  in  3  action code 0..7.
- act_ready  out  1  monitor accepts an action this cycle.
- x  out  3  current column (registered).
- y  out  3  current row (registered).
- steps  out  8  accepted steps this episode.
- done  out  1  verdict reached (sticky until start/rst).
- accept  out  1  episode satisfied spec (valid when done).
- reject  out  1  episode violated spec or timed out (valid when done).
- timeout  out  1  reject cause was horizon expiry.

## Operation
- States: IDLE, RUN, PEND (blue obligation open, deadline counter dl active), ACC, REJ.
- Movement: x' = x+{0,+1,-1} and y' = y+{0,+1,-1}, modulo 8 (7+1=0, 0-1=7).
  - X component: act 0,4 stay; act 1..3 +1; act 5..7 -1.
  - Y component: act 2,6 stay; act 0,1,7 +1; act 3..5 -1.
- Predicates on a cell (cx,cy):
  - blue = cx in 3..4 and cy in 2..5.
  - yellow = cx in {0,7} and cy in {0,7}.
  - brown = cy in {0,7}, any column.
  - red = (cx in {1,6} and cy in {0,1,4,5}) or (cx in {0,7} and cy in {1,4,5}).
- Cell evaluation, applied to the start cell on start and to every new cell after a step, first match wins:
  - red → REJ.
  - brown → pending cleared, then yellow → ACC, else RUN.
  - blue → PEND, dl=DEADLINE.
  - in PEND, dl==1 → REJ; otherwise dl=dl-1.
  - otherwise, state unchanged.
- Horizon: if the evaluation of step number HORIZON leaves the monitor in RUN or PEND → REJ with timeout=1. A red/accept/deadline verdict on that same step takes precedence, and timeout stays 0.
- start: loads x0/y0, steps=0, clears the verdict, evaluates the start cell. It has priority over any action in the same cycle.
- act_ready = (state is RUN or PEND) and not start. A step occurs on act_valid and act_ready.
- steps increments per accepted step and saturates at 255.

## Timing
- Reset values: state IDLE, x=0, y=0, steps=0, dl=0; act_ready=0, done=0, accept=0, reject=0, timeout=0.
- rst mid-episode aborts it immediately; rst has priority over start.
- Step latency 1 cycle: on the edge after the handshake, x/y/steps/state/verdict update together. done/accept/reject are registered from the next-cell evaluation, so they are visible in the same cycle as the new x/y.
- Start latency 1 cycle. A start cell that is red, yellow, or blue takes effect at that edge; e.g. a red start cell gives done=1, reject=1.
- After done, act_ready=0 and act_valid is ignored until start or rst.
- done/accept/reject/timeout are mutually consistent: done = accept or reject; timeout implies reject.
- No combinational path from act to any output; act_valid affects only state.

## Test plan
- Accept path: start(2,2); act 1 → (3,3), PEND. Then act 0 ×4 → (3,4), (3,5), (3,6), (3,7), which clears pending. Then act 6 ×3 → (2,7), (1,7), (0,7) → accept=1, done=1, steps=8.
- Red: start(2,2); act 5 → (1,1) → reject=1, timeout=0, steps=1, act_ready=0 the next cycle.
- Deadline: start(4,3) (blue, PEND); act 2 ×4 → (5,3), (6,3), (7,3), (0,3). Reject is asserted on the 4th step, steps=4.
- Horizon: start(2,2); act 4 ×16 with wrap → row sequence 1, 0, 7, …, 2. reject=1, timeout=1 after step 16 at (2,2).
- Control:
  - start asserted together with act_valid: action ignored, position = (x0,y0).
  - rst asserted mid-episode: all outputs return to reset values on the next edge.
  - act_valid held with done=1: x/y/steps unchanged.
